// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler sharing one valid/ready consumer between NUM_CH
// synchronous FIFOs with one-cycle registered read latency.
module fifo_rr_sched #(
   parameter int NUM_CH     = 4,
   parameter int CH_BITS    = 2,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = 4,
   parameter int BURST_BITS = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            ch_empty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_pop,
   output logic [NUM_CH-1:0]            ch_flush,
   input  logic                         i_flush,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [CH_BITS-1:0]           o_ch,
   output logic                         o_busy
);

   typedef enum logic [1:0] {IDLE, POP, LOAD, OUT} state_t;

   state_t                 state;
   logic [CH_BITS-1:0]     grant;
   logic [CH_BITS-1:0]     last_grant;
   logic [CH_BITS-1:0]     arb_grant;
   logic [CH_BITS-1:0]     cand;
   logic                   arb_found;
   logic [BURST_BITS-1:0]  burst_cnt;
   logic [BURST_BITS-1:0]  burst_nxt;
   logic [DATA_WIDTH-1:0]  words [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_words
      assign words[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search starts just after the last served channel, so it gets lowest priority.
   always_comb begin
      arb_grant = last_grant;
      arb_found = 1'b0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         cand = CH_BITS'((32'(last_grant) + k) % NUM_CH);
         if (!arb_found && !ch_empty[cand]) begin
            arb_grant = cand;
            arb_found = 1'b1;
         end
      end
   end

   always_comb begin
      ch_pop = '0;
      if (state == POP && !i_flush && !ch_empty[grant]) begin
         ch_pop[grant] = 1'b1;
      end
   end

   assign ch_flush  = {NUM_CH{i_flush}};
   assign o_busy    = (state != IDLE);
   assign burst_nxt = burst_cnt + BURST_BITS'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= CH_BITS'(NUM_CH - 1);
         burst_cnt  <= '0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_ch       <= '0;
      end else if (i_flush) begin
         state     <= IDLE;
         o_valid   <= 1'b0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant     <= arb_grant;
                  burst_cnt <= '0;
                  state     <= POP;
               end
            end
            POP: begin
               if (!ch_empty[grant]) begin
                  state <= LOAD;
               end else begin
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
            LOAD: begin
               o_data  <= words[grant];
               o_ch    <= grant;
               o_valid <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               if (o_ready) begin
                  o_valid   <= 1'b0;
                  burst_cnt <= burst_nxt;
                  if (burst_nxt < BURST_BITS'(BURST_LEN) && !ch_empty[grant]) begin
                     state <= POP;
                  end else begin
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: queue-based FIFO models on the read side plus a
// transaction-level round-robin model that predicts every output word.
module tb_fifo_rr_sched;
   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int BL  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ch_empty = '1;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_pop;
   logic [NCH-1:0]    ch_flush;
   logic              i_flush;
   logic              o_valid;
   logic              o_ready;
   logic [DW-1:0]     o_data;
   logic [1:0]        o_ch;
   logic              o_busy;

   fifo_rr_sched #(
      .NUM_CH(NCH), .CH_BITS(2), .DATA_WIDTH(DW), .BURST_LEN(BL), .BURST_BITS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_empty(ch_empty), .ch_data(ch_data),
      .ch_pop(ch_pop), .ch_flush(ch_flush), .i_flush(i_flush),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ch(o_ch),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ch;
      logic [15:0] data;
   } ent_t;

   int checks   = 0;
   int failures = 0;

   // FIFO models: words in flight, pushes pending until the next edge, read registers
   ent_t        fq[$];
   ent_t        fpend[$];
   logic [DW-1:0] dout [NCH];

   // Scoreboard model: words expected downstream, arbitration memory
   ent_t mq[$];
   int   m_last = NCH - 1;
   int   m_cur  = -1;
   int   m_cnt  = 0;
   int   obs_ch[$];
   int   exp_seq[$];

   always_comb begin
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = dout[i];
   end

   function automatic int fifo_find(int c);
      for (int j = 0; j < fq.size(); j++) if (fq[j].ch == c) return j;
      return -1;
   endfunction

   function automatic int model_find(int c);
      for (int j = 0; j < mq.size(); j++) if (mq[j].ch == c) return j;
      return -1;
   endfunction

   function automatic int predict();
      if (m_cur >= 0) return m_cur;
      for (int k = 1; k <= NCH; k++) begin
         if (model_find((m_last + k) % NCH) >= 0) return (m_last + k) % NCH;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int idx;
      for (int i = 0; i < NCH; i++) begin
         if (ch_flush[i]) begin
            for (int j = fq.size() - 1; j >= 0; j--) if (fq[j].ch == i) fq.delete(j);
         end else if (ch_pop[i]) begin
            checks++;
            idx = fifo_find(i);
            if (idx < 0) begin
               failures++;
               $display("FAIL fifo_pop_empty: pop on empty ch%0d, required no pop", i);
            end else begin
               dout[i] <= fq[idx].data;
               fq.delete(idx);
            end
         end
      end
      while (fpend.size() > 0) fq.push_back(fpend.pop_front());
      for (int i = 0; i < NCH; i++) ch_empty[i] <= (fifo_find(i) < 0);
   end

   task automatic push(input int c, input logic [15:0] d);
      ent_t e;
      e.ch = c;
      e.data = d;
      fpend.push_back(e);
      mq.push_back(e);
   endtask

   task automatic fail_line(input string nm, input logic [31:0] act, input logic [31:0] exp);
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) fail_line(nm, act, exp);
   endtask

   // Per-cycle compare, sampled just before each rising edge
   logic          prev_pop  = 1'b0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] hold_d;
   logic [1:0]    hold_c;

   always @(negedge clk) begin
      int c;
      int idx;
      #4;
      if (!rst_n) begin
         prev_pop  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("ch_flush_mirror", 32'(ch_flush), i_flush ? 32'hF : 32'h0);
         chk("pop_onehot", 32'($countones(ch_pop) > 1 || (i_flush && ch_pop != 0)), 32'h0);
         if (ch_pop != 0) chk("pop_width", 32'(prev_pop), 32'h0);
         if (prev_hold) begin
            chk("hold_valid", 32'(o_valid), 32'h1);
            chk("hold_data", 32'(o_data), 32'(hold_d));
            chk("hold_ch", 32'(o_ch), 32'(hold_c));
         end
         if (i_flush) begin
            mq.delete();
            m_cur = -1;
            m_cnt = 0;
         end else if (o_valid && o_ready) begin
            c = predict();
            obs_ch.push_back(int'(o_ch));
            if (c < 0) begin
               chk("unexpected_word", 32'(o_ch), 32'hFFFF_FFFF);
            end else begin
               idx = model_find(c);
               chk("word_ch", 32'(o_ch), 32'(c));
               chk("word_data", 32'(o_data), 32'(mq[idx].data));
               mq.delete(idx);
               if (m_cur < 0) begin
                  m_cur = c;
                  m_cnt = 0;
               end
               m_cnt++;
               if (m_cnt == BL || model_find(c) < 0) begin
                  m_last = c;
                  m_cur  = -1;
                  m_cnt  = 0;
               end
            end
         end
         prev_pop  = (ch_pop != 0);
         prev_hold = o_valid && !o_ready && !i_flush;
         hold_d    = o_data;
         hold_c    = o_ch;
      end
   end

   task automatic wait_drain(input string nm);
      int n = 0;
      while (n < 300 && !(mq.size() == 0 && !o_busy)) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 300), 32'h1);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (n < 50 && !o_valid) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(o_valid), 32'h1);
   endtask

   task automatic check_seq(input string nm);
      chk({nm, "_len"}, 32'(obs_ch.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < obs_ch.size(); i++) begin
         chk(nm, 32'(obs_ch[i]), 32'(exp_seq[i]));
      end
      obs_ch.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n   = 1'b1;
      i_flush = 1'b0;
      o_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_pop", 32'(ch_pop), 32'h0);
      chk("rst_data", 32'(o_data), 32'h0);
      chk("rst_ch", 32'(o_ch), 32'h0);
      chk("rst_flush", 32'(ch_flush), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // First word: latency from non-empty in IDLE to pop and valid
      @(negedge clk);
      push(2, 16'hA5A5);
      @(posedge clk);
      @(negedge clk);
      chk("t0_pop", 32'(ch_pop), 32'h0);
      @(negedge clk);
      chk("t1_pop", 32'(ch_pop), 32'h4);
      chk("t1_busy", 32'(o_busy), 32'h1);
      @(negedge clk);
      chk("t2_valid", 32'(o_valid), 32'h0);
      chk("t2_pop", 32'(ch_pop), 32'h0);
      @(negedge clk);
      chk("t3_valid", 32'(o_valid), 32'h1);
      chk("t3_data", 32'(o_data), 32'hA5A5);
      chk("t3_ch", 32'(o_ch), 32'h2);
      @(negedge clk);
      chk("t4_valid", 32'(o_valid), 32'h0);
      chk("t4_busy", 32'(o_busy), 32'h0);
      obs_ch.delete();

      push(3, 16'h3333);
      wait_drain("drain_ch3");
      exp_seq = '{3};
      check_seq("wrap_order");

      // Round robin over all channels, then refill 0 and 3
      for (int i = 0; i < NCH; i++) push(i, 16'(16'h1000 + i));
      wait_drain("drain_rr");
      exp_seq = '{0, 1, 2, 3};
      check_seq("rr_order");
      push(0, 16'h1100);
      push(3, 16'h1103);
      wait_drain("drain_refill");
      exp_seq = '{0, 3};
      check_seq("refill_order");
      push(0, 16'h1200);
      wait_drain("drain_ch0");
      obs_ch.delete();

      // Burst limit
      for (int k = 0; k < 6; k++) push(1, 16'(16'h2100 + k));
      push(0, 16'h2000);
      wait_drain("drain_burst");
      exp_seq = '{1, 1, 1, 1, 0, 1, 1};
      check_seq("burst_order");

      // Backpressure
      o_ready = 1'b0;
      push(2, 16'h4400);
      push(2, 16'h4401);
      wait_valid("bp_valid");
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_valid", 32'(o_valid), 32'h1);
         chk("bp_hold_data", 32'(o_data), 32'h4400);
         chk("bp_hold_ch", 32'(o_ch), 32'h2);
         chk("bp_no_pop", 32'(ch_pop), 32'h0);
         @(negedge clk);
      end
      o_ready = 1'b1;
      @(negedge clk);
      chk("bp_next_pop", 32'(ch_pop), 32'h4);
      wait_drain("drain_bp");
      exp_seq = '{2, 2};
      check_seq("bp_order");

      // Flush mid-burst, then confirm last_grant survived
      o_ready = 1'b0;
      for (int k = 0; k < 3; k++) push(3, 16'(16'h5500 + k));
      wait_valid("fl_valid");
      i_flush = 1'b1;
      #1;
      chk("fl_ch_flush", 32'(ch_flush), 32'hF);
      chk("fl_no_pop", 32'(ch_pop), 32'h0);
      @(negedge clk);
      i_flush = 1'b0;
      chk("fl_valid_drop", 32'(o_valid), 32'h0);
      chk("fl_idle", 32'(o_busy), 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("fl_quiet_pop", 32'(ch_pop), 32'h0);
         chk("fl_quiet_valid", 32'(o_valid), 32'h0);
      end
      o_ready = 1'b1;
      exp_seq = {};
      check_seq("fl_order");
      push(3, 16'h5A03);
      push(0, 16'h5A00);
      wait_drain("drain_after_flush");
      exp_seq = '{3, 0};
      check_seq("post_flush_order");

      // Async reset during LOAD
      push(2, 16'h6602);
      push(0, 16'h6600);
      n = 0;
      while (n < 20 && ch_pop == 0) begin
         @(negedge clk);
         n++;
      end
      chk("rs_pop_seen", 32'(ch_pop), 32'h4);
      @(negedge clk);
      #2 rst_n = 1'b0;
      begin
         int c;
         int idx;
         c = predict();
         idx = model_find(c);
         if (idx >= 0) mq.delete(idx);
         m_last = NCH - 1;
         m_cur  = -1;
         m_cnt  = 0;
      end
      #1;
      chk("rs_valid", 32'(o_valid), 32'h0);
      chk("rs_pop", 32'(ch_pop), 32'h0);
      chk("rs_busy", 32'(o_busy), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      wait_drain("drain_after_reset");
      exp_seq = '{0};
      check_seq("post_reset_order");
      repeat (3) @(negedge clk);
      chk("fifos_drained", 32'(ch_empty), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
